// File: rtl/uart_rx_pkg.sv
// Shared helpers for the UART receiver slice.
package uart_rx_pkg;

  // Clock cycles per line bit, using integer division.
  function automatic int bitPeriod(input int clkHz, input int baud);
    return clkHz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus received-word handshake of the UART receiver.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rxd;
  logic [DATA_WIDTH-1:0] axiod;
  logic                  axiov;
  logic                  frame_err;

  // Side that drives the line and consumes received words.
  modport master (
    output rxd,
    input  axiod,
    input  axiov,
    input  frame_err
  );

  // Side that samples the line and produces received words.
  modport slave (
    input  rxd,
    output axiod,
    output axiov,
    output frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, start-edge detect, mid-bit sampling
// FSM, LSB-first shift register and one-cycle valid / framing-error strobes.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int CLK_FREQ_HZ = 100000000,
  parameter int BAUDRATE    = 115200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxd,
  output logic [DATA_WIDTH-1:0] axiod,
  output logic                  axiov,
  output logic                  frame_err
);

  localparam int P     = bitPeriod(CLK_FREQ_HZ, BAUDRATE);
  localparam int H     = P / 2;
  localparam int CNT_W = $clog2(P);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(H - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(P - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  // A bit period shorter than four clocks leaves no room for mid-bit sampling.
  if (P < 4) begin : g_periodCheck
    $error("uart_rx: CLK_FREQ_HZ / BAUDRATE must be at least 4");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                r_state;
  logic                  r_sync1;
  logic                  r_rxs;
  logic [1:0]            r_warm;
  logic                  r_rxPrev;
  logic [CNT_W-1:0]      r_baudCnt;
  logic [BIT_W-1:0]      r_bitCnt;
  logic [DATA_WIDTH-1:0] r_shift;

  logic                  w_startEdge;
  logic [DATA_WIDTH:0]   w_shiftWide;
  logic [DATA_WIDTH-1:0] w_shiftNext;

  // r_rxPrev only reports high once the synchronizer holds real line data,
  // so a line still low after reset is never mistaken for a start edge.
  assign w_startEdge = r_rxPrev & ~r_rxs;
  assign w_shiftWide = {r_rxs, r_shift} >> 1;
  assign w_shiftNext = w_shiftWide[DATA_WIDTH-1:0];

  // Synchronize the line and track its previous value once the flops are warm.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= 1'b1;
      r_rxs    <= 1'b1;
      r_warm   <= 2'b00;
      r_rxPrev <= 1'b0;
    end else begin
      r_sync1  <= rxd;
      r_rxs    <= r_sync1;
      r_warm   <= {r_warm[0], 1'b1};
      r_rxPrev <= r_rxs & r_warm[1];
    end
  end

  // Frame FSM with baud/bit counters, shift register and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_baudCnt <= '0;
      r_bitCnt  <= '0;
      r_shift   <= '0;
      axiod     <= '0;
      axiov     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      axiov     <= 1'b0;
      frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_baudCnt <= '0;
          r_bitCnt  <= '0;
          if (w_startEdge) begin
            r_state <= START;
          end
        end
        START: begin
          if (r_baudCnt == HALF_LAST) begin
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            r_state   <= r_rxs ? IDLE : DATA;
          end else begin
            r_baudCnt <= r_baudCnt + CNT_ONE;
          end
        end
        DATA: begin
          if (r_baudCnt == FULL_LAST) begin
            r_baudCnt <= '0;
            r_shift   <= w_shiftNext;
            if (r_bitCnt == LAST_BIT) begin
              r_state <= STOP;
            end else begin
              r_bitCnt <= r_bitCnt + BIT_ONE;
            end
          end else begin
            r_baudCnt <= r_baudCnt + CNT_ONE;
          end
        end
        STOP: begin
          if (r_baudCnt == FULL_LAST) begin
            r_baudCnt <= '0;
            r_state   <= IDLE;
            if (r_rxs) begin
              axiod <= r_shift;
              axiov <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            r_baudCnt <= r_baudCnt + CNT_ONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: 12 MHz clock, 1 Mbaud, 12 clocks per bit.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int DW     = 8;
  localparam int CLK_HZ = 12000000;
  localparam int BAUD   = 1000000;
  localparam int P      = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;

  uart_rx_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx #(
    .DATA_WIDTH (DW),
    .CLK_FREQ_HZ(CLK_HZ),
    .BAUDRATE   (BAUD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rxd      (bus.rxd),
    .axiod    (bus.axiod),
    .axiov    (bus.axiov),
    .frame_err(bus.frame_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nValid = 0;
  int nErr = 0;
  int nOverlap = 0;
  int lastValidCyc = 0;
  int lastStartCyc = 0;
  logic [DW-1:0] rxQ[$];

  // Cycle counter used to time strobes against the start bit.
  always @(posedge clk) cyc <= cyc + 1;

  // Record strobes on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus.axiov) begin
      nValid++;
      rxQ.push_back(bus.axiod);
      lastValidCyc = cyc;
    end
    if (bus.frame_err) nErr++;
    if (bus.axiov && bus.frame_err) nOverlap++;
  end

  task automatic holdLine(input logic v, input int n);
    bus.rxd = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sendFrame(input logic [DW-1:0] data, input logic stopBit);
    lastStartCyc = cyc;
    holdLine(1'b0, P);
    for (int i = 0; i < DW; i++) holdLine(data[i], P);
    holdLine(stopBit, P);
  endtask

  task automatic clearMon();
    nValid = 0;
    nErr = 0;
    rxQ.delete();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.rxd = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (bus.axiod !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_axiod: got %h expected 00", bus.axiod);
    end
    checks++;
    if (bus.axiov !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_axiov: got %b expected 0", bus.axiov);
    end
    checks++;
    if (bus.frame_err !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_frame_err: got %b expected 0", bus.frame_err);
    end
    rst = 1'b1;
    holdLine(1'b1, 10);
  endtask

  task automatic test_single_frame();
    clearMon();
    sendFrame(8'hA5, 1'b1);
    holdLine(1'b1, 5);
    checks++;
    if (nValid !== 1) begin
      errors++; $display("[TB] FAIL single_count: got %0d strobes expected 1", nValid);
    end
    checks++;
    if (rxQ.size() < 1 || rxQ[0] !== 8'hA5) begin
      errors++; $display("[TB] FAIL single_data: got %h expected a5", bus.axiod);
    end
    checks++;
    if (nErr !== 0) begin
      errors++; $display("[TB] FAIL single_frame_err: got %0d expected 0", nErr);
    end
    checks++;
    if (lastValidCyc - lastStartCyc !== 117) begin
      errors++; $display("[TB] FAIL single_latency: got %0d cycles expected 117", lastValidCyc - lastStartCyc);
    end
  endtask

  task automatic test_back_to_back();
    clearMon();
    sendFrame(8'h00, 1'b1);
    sendFrame(8'hFF, 1'b1);
    holdLine(1'b1, 5);
    checks++;
    if (nValid !== 2) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d strobes expected 2", nValid);
    end
    checks++;
    if (rxQ.size() < 2 || rxQ[0] !== 8'h00 || rxQ[1] !== 8'hFF) begin
      errors++; $display("[TB] FAIL b2b_data: got %0d words last %h expected 00 then ff", rxQ.size(), bus.axiod);
    end
    checks++;
    if (nErr !== 0) begin
      errors++; $display("[TB] FAIL b2b_frame_err: got %0d expected 0", nErr);
    end
  endtask

  task automatic test_glitch();
    clearMon();
    holdLine(1'b0, 3);
    holdLine(1'b1, 30);
    checks++;
    if (nValid !== 0 || nErr !== 0) begin
      errors++; $display("[TB] FAIL glitch_strobes: got valid %0d err %0d expected 0 0", nValid, nErr);
    end
    checks++;
    if (bus.axiod !== 8'hFF) begin
      errors++; $display("[TB] FAIL glitch_hold: got %h expected ff", bus.axiod);
    end
    sendFrame(8'h96, 1'b1);
    holdLine(1'b1, 5);
    checks++;
    if (nValid !== 1 || rxQ.size() < 1 || rxQ[0] !== 8'h96) begin
      errors++; $display("[TB] FAIL glitch_recover: got %0d strobes data %h expected 1 96", nValid, bus.axiod);
    end
  endtask

  task automatic test_frame_error();
    clearMon();
    sendFrame(8'h3C, 1'b0);
    holdLine(1'b0, 40);
    holdLine(1'b1, 20);
    checks++;
    if (nErr !== 1) begin
      errors++; $display("[TB] FAIL ferr_count: got %0d expected 1", nErr);
    end
    checks++;
    if (nValid !== 0) begin
      errors++; $display("[TB] FAIL ferr_no_valid: got %0d expected 0", nValid);
    end
    checks++;
    if (bus.axiod !== 8'h96) begin
      errors++; $display("[TB] FAIL ferr_hold: got %h expected 96", bus.axiod);
    end
    clearMon();
    sendFrame(8'h11, 1'b1);
    holdLine(1'b1, 5);
    checks++;
    if (nValid !== 1 || nErr !== 0 || rxQ.size() < 1 || rxQ[0] !== 8'h11) begin
      errors++; $display("[TB] FAIL ferr_recover: got valid %0d err %0d data %h expected 1 0 11", nValid, nErr, bus.axiod);
    end
  endtask

  task automatic test_reset_midframe();
    logic [DW-1:0] d;
    d = 8'h5A;
    clearMon();
    holdLine(1'b0, P);
    for (int i = 0; i < 4; i++) holdLine(d[i], P);
    holdLine(d[4], 5);
    rst = 1'b0;
    holdLine(1'b0, 4);
    checks++;
    if (bus.axiod !== 8'h00 || bus.axiov !== 1'b0 || bus.frame_err !== 1'b0) begin
      errors++; $display("[TB] FAIL midrst_outputs: got %h %b %b expected 00 0 0", bus.axiod, bus.axiov, bus.frame_err);
    end
    rst = 1'b1;
    holdLine(1'b0, 30);
    holdLine(1'b1, 20);
    checks++;
    if (nValid !== 0 || nErr !== 0) begin
      errors++; $display("[TB] FAIL midrst_no_strobe: got valid %0d err %0d expected 0 0", nValid, nErr);
    end
    sendFrame(8'h77, 1'b1);
    holdLine(1'b1, 5);
    checks++;
    if (nValid !== 1 || nErr !== 0 || rxQ.size() < 1 || rxQ[0] !== 8'h77) begin
      errors++; $display("[TB] FAIL midrst_recover: got valid %0d err %0d data %h expected 1 0 77", nValid, nErr, bus.axiod);
    end
  endtask

  task automatic test_loopback();
    logic [DW-1:0] expQ[$];
    logic [DW-1:0] b;
    clearMon();
    for (int i = 0; i < 256; i++) begin
      b = 8'($urandom_range(0, 255));
      expQ.push_back(b);
      sendFrame(b, 1'b1);
    end
    holdLine(1'b1, 5);
    checks++;
    if (nValid !== 256) begin
      errors++; $display("[TB] FAIL loop_count: got %0d expected 256", nValid);
    end
    checks++;
    if (nErr !== 0) begin
      errors++; $display("[TB] FAIL loop_frame_err: got %0d expected 0", nErr);
    end
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (i >= rxQ.size() || rxQ[i] !== expQ[i]) begin
        errors++; $display("[TB] FAIL loop_data[%0d]: got %h expected %h", i, (i < rxQ.size()) ? rxQ[i] : 8'hxx, expQ[i]);
      end
    end
  endtask

  task automatic test_no_overlap();
    checks++;
    if (nOverlap !== 0) begin
      errors++; $display("[TB] FAIL strobe_overlap: got %0d cycles expected 0", nOverlap);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    bus.rxd = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] starting uart_rx directed tests");
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
    test_loopback();
    test_no_overlap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
